// File: rtl/jkff_pkg.sv
// Shared mode encoding for the JK/D/T/SR flip-flop bank.
package jkff_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_t;

endpackage

// File: rtl/jkff_bank_if.sv
// Control/data bundle between a bank controller (master) and jkff_bank (slave).
interface jkff_bank_if #(
    parameter int WIDTH = 8
);
    import jkff_pkg::*;

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] changed;
    logic             err;

    modport master (
        output en, mode, j, k, err_clr,
        input  q, qbar, changed, err
    );

    modport slave (
        input  en, mode, j, k, err_clr,
        output q, qbar, changed, err
    );

endinterface

// File: rtl/jkff_cell.sv
// Next-state logic for one bit of the bank; purely combinational.
module jkff_cell
    import jkff_pkg::*;
(
    input  logic  q,
    input  logic  j,
    input  logic  k,
    input  mode_t mode,
    output logic  q_next,
    output logic  illegal
);

    always_comb begin
        q_next  = q;
        illegal = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_D:  q_next = j;
            MODE_T:  q_next = q ^ j;
            MODE_SR: begin
                // S=R=1 is flagged but the bit keeps its value
                case ({j, k})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   illegal = 1'b1;
                    default: q_next = q;
                endcase
            end
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/jkff_bank.sv
// Bank of WIDTH configurable flip-flops with change pulses and a sticky SR-illegal flag.
module jkff_bank
    import jkff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    jkff_bank_if.slave  bus
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qbar_r;
    logic [WIDTH-1:0] changed_r;
    logic             err_r;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] illegal;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jkff_cell u_cell (
            .q       (q_r[i]),
            .j       (bus.j[i]),
            .k       (bus.k[i]),
            .mode    (bus.mode),
            .q_next  (q_next[i]),
            .illegal (illegal[i])
        );
    end

    // qbar is registered from the same next-state so it never lags q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r       <= RESET_VAL;
            qbar_r    <= ~RESET_VAL;
            changed_r <= '0;
            err_r     <= 1'b0;
        end else begin
            if (bus.en) begin
                q_r       <= q_next;
                qbar_r    <= ~q_next;
                changed_r <= q_next ^ q_r;
            end else begin
                changed_r <= '0;
            end
            // a new illegal condition wins over a simultaneous clear
            if (bus.en && (|illegal)) begin
                err_r <= 1'b1;
            end else if (bus.err_clr) begin
                err_r <= 1'b0;
            end
        end
    end

    assign bus.q       = q_r;
    assign bus.qbar    = qbar_r;
    assign bus.changed = changed_r;
    assign bus.err     = err_r;

endmodule

// File: tb/tb_jkff_bank.sv
// Self-checking bench for jkff_bank: directed tables plus randomized run against a word-level model.
module tb_jkff_bank;
    import jkff_pkg::*;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    typedef struct packed {
        logic       rst_n;
        logic       en;
        mode_t      mode;
        logic [7:0] j;
        logic [7:0] k;
        logic       clr;
        logic [7:0] eq;
        logic [7:0] ech;
        logic       eerr;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] m_q, m_ch;
    logic       m_err;

    jkff_bank_if #(.WIDTH(W)) bus ();

    jkff_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Word-level reference: characteristic equations, not per-bit cases
    task automatic tick();
        logic [7:0] nq;
        @(posedge clk);
        if (!rst_n) begin
            m_q   = RV;
            m_ch  = 8'h00;
            m_err = 1'b0;
        end else begin
            nq = m_q;
            if (bus.en) begin
                case (bus.mode)
                    MODE_JK: nq = (bus.j & ~m_q) | (~bus.k & m_q);
                    MODE_D:  nq = bus.j;
                    MODE_T:  nq = m_q ^ bus.j;
                    default: nq = (m_q | (bus.j & ~bus.k)) & ~(bus.k & ~bus.j);
                endcase
            end
            m_ch = nq ^ m_q;
            if (bus.en && bus.mode == MODE_SR && (bus.j & bus.k) != 8'h00) m_err = 1'b1;
            else if (bus.err_clr) m_err = 1'b0;
            m_q = nq;
        end
        #1;
    endtask

    task automatic apply(input step_t s);
        rst_n       = s.rst_n;
        bus.en      = s.en;
        bus.mode    = s.mode;
        bus.j       = s.j;
        bus.k       = s.k;
        bus.err_clr = s.clr;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.en = 1'b1; bus.mode = MODE_JK; bus.j = 8'hFF; bus.k = 8'hFF; bus.err_clr = 1'b0;
        tick();
        checks += 4;
        if (bus.q !== 8'hA5) begin failures++; $display("FAIL reset_q got=%h exp=a5", bus.q); end
        if (bus.qbar !== 8'h5A) begin failures++; $display("FAIL reset_qbar got=%h exp=5a", bus.qbar); end
        if (bus.changed !== 8'h00) begin failures++; $display("FAIL reset_changed got=%h exp=00", bus.changed); end
        if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        rst_n = 1'b1;
    endtask

    task automatic test_jk();
        step_t t[5];
        t = '{'{1'b0, 1'b1, MODE_D,  8'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0},
              '{1'b1, 1'b1, MODE_D,  8'h00, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0},
              '{1'b1, 1'b1, MODE_JK, 8'hF0, 8'h0F, 1'b0, 8'hF0, 8'hF0, 1'b0},
              '{1'b1, 1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0, 8'h0F, 8'hFF, 1'b0},
              '{1'b1, 1'b1, MODE_JK, 8'h00, 8'h00, 1'b0, 8'h0F, 8'h00, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            apply(t[i]);
            checks += 4;
            if (bus.q !== t[i].eq) begin failures++; $display("FAIL jk_q step=%0d got=%h exp=%h", i, bus.q, t[i].eq); end
            if (bus.qbar !== ~t[i].eq) begin failures++; $display("FAIL jk_qbar step=%0d got=%h exp=%h", i, bus.qbar, ~t[i].eq); end
            if (bus.changed !== t[i].ech) begin failures++; $display("FAIL jk_changed step=%0d got=%h exp=%h", i, bus.changed, t[i].ech); end
            if (bus.err !== t[i].eerr) begin failures++; $display("FAIL jk_err step=%0d got=%b exp=%b", i, bus.err, t[i].eerr); end
        end
    endtask

    task automatic test_d_t_hold();
        step_t t[5];
        t = '{'{1'b0, 1'b1, MODE_D, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0},
              '{1'b1, 1'b1, MODE_D, 8'h3C, 8'hFF, 1'b0, 8'h3C, 8'h99, 1'b0},
              '{1'b1, 1'b1, MODE_T, 8'hFF, 8'h00, 1'b0, 8'hC3, 8'hFF, 1'b0},
              '{1'b1, 1'b0, MODE_T, 8'hFF, 8'h00, 1'b0, 8'hC3, 8'h00, 1'b0},
              '{1'b1, 1'b0, MODE_D, 8'h00, 8'h00, 1'b0, 8'hC3, 8'h00, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            apply(t[i]);
            checks += 4;
            if (bus.q !== t[i].eq) begin failures++; $display("FAIL dt_q step=%0d got=%h exp=%h", i, bus.q, t[i].eq); end
            if (bus.qbar !== ~t[i].eq) begin failures++; $display("FAIL dt_qbar step=%0d got=%h exp=%h", i, bus.qbar, ~t[i].eq); end
            if (bus.changed !== t[i].ech) begin failures++; $display("FAIL dt_changed step=%0d got=%h exp=%h", i, bus.changed, t[i].ech); end
            if (bus.err !== t[i].eerr) begin failures++; $display("FAIL dt_err step=%0d got=%b exp=%b", i, bus.err, t[i].eerr); end
        end
    endtask

    task automatic test_sr_err();
        step_t t[8];
        t = '{'{1'b0, 1'b1, MODE_D,  8'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0},
              '{1'b1, 1'b1, MODE_D,  8'h00, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0},
              '{1'b1, 1'b1, MODE_SR, 8'h81, 8'h01, 1'b0, 8'h80, 8'h80, 1'b1},
              '{1'b1, 1'b1, MODE_SR, 8'h00, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0},
              '{1'b1, 1'b1, MODE_SR, 8'h01, 8'h01, 1'b1, 8'h80, 8'h00, 1'b1},
              '{1'b1, 1'b0, MODE_SR, 8'hFF, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0},
              '{1'b1, 1'b0, MODE_SR, 8'hFF, 8'hFF, 1'b0, 8'h80, 8'h00, 1'b0},
              '{1'b1, 1'b1, MODE_SR, 8'hF0, 8'h3C, 1'b0, 8'hC0, 8'h40, 1'b1}};
        for (int i = 0; i < 8; i++) begin
            apply(t[i]);
            checks += 4;
            if (bus.q !== t[i].eq) begin failures++; $display("FAIL sr_q step=%0d got=%h exp=%h", i, bus.q, t[i].eq); end
            if (bus.qbar !== ~t[i].eq) begin failures++; $display("FAIL sr_qbar step=%0d got=%h exp=%h", i, bus.qbar, ~t[i].eq); end
            if (bus.changed !== t[i].ech) begin failures++; $display("FAIL sr_changed step=%0d got=%h exp=%h", i, bus.changed, t[i].ech); end
            if (bus.err !== t[i].eerr) begin failures++; $display("FAIL sr_err step=%0d got=%b exp=%b", i, bus.err, t[i].eerr); end
        end
    endtask

    task automatic test_mid_reset();
        step_t t[6];
        t = '{'{1'b0, 1'b1, MODE_D,  8'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0},
              '{1'b1, 1'b1, MODE_D,  8'h0F, 8'h00, 1'b0, 8'h0F, 8'hAA, 1'b0},
              '{1'b1, 1'b1, MODE_SR, 8'h01, 8'h01, 1'b0, 8'h0F, 8'h00, 1'b1},
              '{1'b0, 1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0, 8'hA5, 8'h00, 1'b0},
              '{1'b1, 1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0, 8'h5A, 8'hFF, 1'b0},
              '{1'b1, 1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0, 8'hA5, 8'hFF, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            apply(t[i]);
            checks += 4;
            if (bus.q !== t[i].eq) begin failures++; $display("FAIL mrst_q step=%0d got=%h exp=%h", i, bus.q, t[i].eq); end
            if (bus.qbar !== ~t[i].eq) begin failures++; $display("FAIL mrst_qbar step=%0d got=%h exp=%h", i, bus.qbar, ~t[i].eq); end
            if (bus.changed !== t[i].ech) begin failures++; $display("FAIL mrst_changed step=%0d got=%h exp=%h", i, bus.changed, t[i].ech); end
            if (bus.err !== t[i].eerr) begin failures++; $display("FAIL mrst_err step=%0d got=%b exp=%b", i, bus.err, t[i].eerr); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n       = ($urandom_range(0, 24) != 0);
            bus.en      = ($urandom_range(0, 3) != 0);
            bus.mode    = mode_t'($urandom_range(0, 3));
            bus.j       = 8'($urandom);
            bus.k       = 8'($urandom);
            if ($urandom_range(0, 2) != 0) bus.k = bus.k & ~bus.j;
            bus.err_clr = ($urandom_range(0, 3) == 0);
            tick();
            checks += 4;
            if (bus.q !== m_q) begin failures++; $display("FAIL rnd_q cyc=%0d got=%h exp=%h", i, bus.q, m_q); end
            if (bus.qbar !== ~m_q) begin failures++; $display("FAIL rnd_qbar cyc=%0d got=%h exp=%h", i, bus.qbar, ~m_q); end
            if (bus.changed !== m_ch) begin failures++; $display("FAIL rnd_changed cyc=%0d got=%h exp=%h", i, bus.changed, m_ch); end
            if (bus.err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, bus.err, m_err); end
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.mode = MODE_JK; bus.j = 8'h00; bus.k = 8'h00; bus.err_clr = 1'b0;
        m_q = 8'h00; m_ch = 8'h00; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_jk();
        test_d_t_hold();
        test_sr_err();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jkff_bank.md
JKFF_BANK -- requirements
Module: jkff_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of independent flip-flop bits (1..64).
REQ-002 Parameter RESET_VAL, default 0 (WIDTH bits), value loaded into q on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  update enable; 0 = hold all bits.
REQ-006 mode  input  2  per-bank function select: 00 JK, 01 D, 10 T, 11 SR.
REQ-007 j  input  WIDTH  per-bit J / D / T / S operand, depending on mode.
REQ-008 k  input  WIDTH  per-bit K / R operand; ignored in D and T modes.
REQ-009 err_clr  input  1  clears the sticky error flag.
REQ-010 q  output  WIDTH  registered state.
REQ-011 qbar  output  WIDTH  registered complement of q.
REQ-012 changed  output  WIDTH  registered one-cycle pulse per bit whose q changed on the last edge.
REQ-013 err  output  1  sticky flag: an illegal SR input was seen.

Function
REQ-014 The block SHALL sample j, k, mode, en and err_clr only on the rising edge of clk; outputs change only on that edge.
REQ-015 Latency SHALL be exactly one cycle: inputs sampled at edge N are reflected on q, qbar, changed and err after edge N.
REQ-016 In mode 00 (JK), per bit: j=0,k=0 hold; j=0,k=1 q<=0; j=1,k=0 q<=1; j=1,k=1 q<=~q.
REQ-017 In mode 01 (D), per bit: q<=j; k ignored.
REQ-018 In mode 10 (T), per bit: q<=q^j; k ignored.
REQ-019 In mode 11 (SR), per bit: j=0,k=0 hold; j=1,k=0 set; j=0,k=1 clear; j=1,k=1 illegal, that bit holds its value.
REQ-020 qbar SHALL equal ~q at every clock edge after reset; the two are never momentarily inconsistent.
REQ-021 changed[i] SHALL be 1 for exactly the cycle after an edge on which q[i] changed value, else 0.
REQ-022 With en=0 all q bits SHALL hold, changed SHALL be 0, err SHALL not be set; err_clr still acts.
REQ-023 err SHALL set when en=1, mode=11 and any bit has j=1,k=1; it SHALL remain set until err_clr=1 or reset.
REQ-024 Simultaneous err_clr=1 and a new illegal SR condition SHALL leave err set (set wins).
REQ-025 Legal bits SHALL update normally in a cycle in which other bits are illegal in SR mode.
REQ-026 A mode change SHALL take effect on the same edge it is sampled; no pipeline or drain state exists.

Reset
REQ-027 When rst_n=0 at a rising edge: q<=RESET_VAL, qbar<=~RESET_VAL, changed<=0, err<=0.
REQ-028 Reset SHALL take priority over en, mode, j, k and err_clr.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight update for that edge; changed SHALL be 0 on the cycle after reset even if q differed from RESET_VAL.
REQ-030 Behaviour before the first reset edge is undefined; verification SHALL not check it.

Structure
REQ-031 A shared package jkff_pkg SHALL hold the 2-bit mode constants (MODE_JK, MODE_D, MODE_T, MODE_SR) and the mode typedef.
REQ-032 One sub-module, jkff_cell, SHALL compute a single bit's next state and illegal indication from q, j, k, mode; jkff_bank instantiates WIDTH copies.
REQ-033 All registers (q, qbar, changed, err) SHALL reside in jkff_bank; jkff_cell is purely combinational.

Verification
REQ-034 WIDTH=8, RESET_VAL=8'hA5, rst_n=0 one edge -> q=A5, qbar=5A, changed=00, err=0.
REQ-035 Mode JK from q=00: j=F0,k=0F -> q=F0; then j=FF,k=FF -> q=0F, changed=FF; then j=00,k=00 -> q=0F, changed=00.
REQ-036 Mode D j=3C then mode T j=FF -> q=3C then C3; en=0 with j=FF -> q stays C3, changed=00.
REQ-037 Mode SR from q=00: j=81,k=01 -> bit0 holds 0, bit7=1, q=80, err=1; err_clr=1 with legal inputs -> err=0; err_clr=1 with illegal inputs -> err stays 1.
REQ-038 Mid-sequence rst_n=0 while mode JK j=k=FF, q=0F -> next q=RESET_VAL, changed=00, err=0; toggling resumes on the first edge with rst_n=1.
REQ-039 Every cycle of every scenario: qbar == ~q and changed == q XOR previous q (after first reset).
